btn_conditioner: RTL



---
 rtl/btn_pkg.sv | 10 +
 rtl/sync_2ff.sv | 25 ++
 rtl/btn_conditioner.sv | 123 ++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types for the button conditioner
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rpt_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic 2-flop synchroniser with selectable reset level
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rst_val,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= i_rst_val;
            r_s2 <= i_rst_val;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - push-button sync, debounce, press edge and auto-repeat
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 10000000,
    parameter bit          ACTIVE_LOW_IN   = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    input  logic repeat_en,
    output logic x_pulse,
    output logic btn_level,
    output logic holding
);

    localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = $clog2(RMAX);

    logic          w_btn_raw;
    logic          w_s2;
    logic          w_commit;
    logic          w_level_nxt;
    logic          w_rise;

    logic [DW-1:0] r_dcnt;
    logic          r_btn_level;
    logic [RW-1:0] r_rcnt;
    rpt_state_t    r_state;
    logic          r_x_pulse;
    logic          r_holding;

    assign w_btn_raw = ACTIVE_LOW_IN ? ~btn_in : btn_in;

    sync_2ff u_sync (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rst_val (1'b0),
        .i_d       (w_btn_raw),
        .o_q       (w_s2)
    );

    // The FSM reacts to the level being committed this edge, so the press
    // pulse lands on the same edge as btn_level rising.
    assign w_commit    = (w_s2 != r_btn_level) && (r_dcnt == DW'(DEBOUNCE_CYCLES - 1));
    assign w_level_nxt = w_commit ? w_s2 : r_btn_level;
    assign w_rise      = w_commit && w_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dcnt      <= '0;
            r_btn_level <= 1'b0;
        end else if (w_s2 == r_btn_level) begin
            r_dcnt <= '0;
        end else if (w_commit) begin
            r_btn_level <= w_s2;
            r_dcnt      <= '0;
        end else begin
            r_dcnt <= r_dcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rcnt    <= '0;
            r_x_pulse <= 1'b0;
            r_holding <= 1'b0;
        end else begin
            r_x_pulse <= 1'b0;
            r_holding <= (r_state == REPEAT);
            // Release wins over any pulse falling due on the same edge.
            if (!w_level_nxt) begin
                r_state <= IDLE;
                r_rcnt  <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_rise) begin
                            r_x_pulse <= 1'b1;
                            r_state   <= DELAY;
                            r_rcnt    <= '0;
                        end
                    end
                    DELAY: begin
                        if (!repeat_en) begin
                            r_rcnt <= '0;
                        end else if (r_rcnt == RW'(REPEAT_DELAY - 1)) begin
                            r_x_pulse <= 1'b1;
                            r_state   <= REPEAT;
                            r_rcnt    <= '0;
                        end else begin
                            r_rcnt <= r_rcnt + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (!repeat_en) begin
                            r_state <= DELAY;
                            r_rcnt  <= '0;
                        end else if (r_rcnt == RW'(REPEAT_PERIOD - 1)) begin
                            r_x_pulse <= 1'b1;
                            r_rcnt    <= '0;
                        end else begin
                            r_rcnt <= r_rcnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_rcnt  <= '0;
                    end
                endcase
            end
        end
    end

    assign x_pulse   = r_x_pulse;
    assign btn_level = r_btn_level;
    assign holding   = r_holding;

endmodule
